instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Program loader that writes the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive word addresses starting at byte address 0. While a load is in progress it holds the fetch stage in reset through `cpu_hold`, so the processor starts from PC 0 once the image is complete.

## Interface
- `ADDR_W`, default 8: word-address width; capacity is 2^ADDR_W words.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request a load session; sampled only in IDLE.
- `load_words`  in  ADDR_W+1  number of words to load; sampled when `start` is accepted.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte; sampled only on a handshake.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  one-cycle instruction-memory write strobe.
- `mem_addr`  out  32  byte address of the write (word index × 4).
- `mem_wdata`  out  32  assembled word.
- `busy`  out  1  high in any state other than IDLE.
- `cpu_hold`  out  1  equals `busy`; drives the fetch stage's reset.
- `done`  out  1  one-cycle pulse at the end of a session.

## Operation
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - With `start`=1 and `load_words`≠0: go to COLLECT, clear word index and byte lane, latch the remaining count.
  - With `load_words`=0: go to DONE with no write.
- Count clamp: a `load_words` value above 2^ADDR_W is clamped to 2^ADDR_W, so the address never wraps.
- COLLECT:
  - `byte_ready`=1.
  - Each handshake (`byte_valid`&`byte_ready`) stores `byte_data` into lane k = bits 8k+7:8k, where k is 0..3 and the first byte goes to bits 7:0.
  - The 4th handshake moves the FSM to WRITE.
- WRITE:
  - `byte_ready`=0 and `mem_we`=1 for exactly one cycle, with `mem_addr`=index×4 and `mem_wdata`=assembled word.
  - Afterwards: index+1, remaining−1. If remaining becomes 0 go to DONE, else go to COLLECT with the lane cleared.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` is ignored outside IDLE.
- `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0; they are don't-care for the memory.
- Arithmetic: index is ADDR_W bits; `mem_addr` = {zero-extend(index), 2'b00}.
- Reset (`reset`=0), any state including mid-word:
  - Next edge: IDLE, index/lane/count cleared.
  - The partial word is discarded.
  - Words already written stay in memory.

## Timing
- Reset values: `byte_ready`, `mem_we`, `busy`, `cpu_hold`, `done` = 0; `mem_addr`, `mem_wdata` = 0.
- `start` accepted at edge N: `busy`/`byte_ready` high from cycle N+1.
- 4th byte handshake at edge M: `mem_we` high in cycle M+1; `byte_ready` high again in cycle M+2.
- Throughput: minimum 5 cycles per word with a back-to-back source.
- Last `mem_we` in cycle W: `done` and `busy` high in cycle W+1; `busy`=0 and `cpu_hold`=0 from cycle W+2.
- `load_words`=0 with `start` at edge N: `done` in cycle N+1.
- No combinational path from `byte_valid` to `byte_ready`.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` [31:0]: the sum modulo 2^32 of every written word.
  - Cleared to 0 on reset and when `start` is accepted.
  - Updated on the cycle after each `mem_we`.
  - Final and stable when `done`=1; holds until the next start.
- Undefined: the port and adder are absent; all other behaviour is identical.

## Test plan
- Reset: drive `reset`=0 for 2 cycles with `byte_valid`=1 and `start`=1 -> all outputs 0, no `mem_we`.
- Back-to-back load, `load_words`=2, bytes 78 56 34 12 EF BE AD DE -> writes 0x12345678 @0x0 and 0xDEADBEEF @0x4, each `mem_we` one cycle wide; `done` one cycle after the second write; with macro, `checksum`=0xF0E21567.
- Same stream with `byte_valid` deasserted on random cycles -> identical writes; no byte lost or duplicated.
- `load_words`=0 -> no `mem_we`; `done` in the cycle after start; `busy` high for exactly 1 cycle.
- Reset after 2 bytes of word 1, then a new 1-word load of 01 02 03 04 -> first partial word never written; new write 0x04030201 @0x0.
- `ADDR_W`=2 and `load_words`=7, with a second `start` pulsed mid-session -> exactly 4 writes @0x0, 0x4, 0x8, 0xC; the second start has no effect.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Byte-stream load / instruction-memory write bundle for instr_mem_loader.
// The checksum signal exists only when LOADER_CHECKSUM_EN is defined.
interface instr_mem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   load_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              cpu_hold;
  logic              done;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       checksum;

  modport slave (
    input  start, load_words, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, checksum
  );
  modport master (
    output start, load_words, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, checksum
  );
`else
  modport slave (
    input  start, load_words, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done
  );
  modport master (
    output start, load_words, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done
  );
`endif
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a little-endian byte stream into instruction memory word by word, holding the CPU meanwhile.
// Optional running sum of written words enabled by LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  instr_mem_loader_if.slave bus
);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_start_acc;
  logic               w_hs;
  logic               w_last_byte;
  logic [CNT_W-1:0]   w_count_clamped;

  logic [CNT_W-1:0]   r_remaining;
  logic [ADDR_W-1:0]  r_index;
  logic [1:0]         r_lane;
  logic [23:0]        r_word;
  logic               r_byte_ready;
  logic               r_mem_we;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;

  // Oversized requests are clamped to memory capacity so the address never wraps.
  assign w_count_clamped = (bus.load_words > MAX_WORDS) ? MAX_WORDS : bus.load_words;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start_acc  = 1'b0;
    w_hs         = 1'b0;
    w_last_byte  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_acc  = 1'b1;
          w_state_next = (bus.load_words == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        w_hs        = bus.byte_valid && r_byte_ready;
        w_last_byte = w_hs && (r_lane == 2'd3);
        if (w_last_byte) w_state_next = S_WRITE;
      end
      S_WRITE:  w_state_next = (r_remaining == CNT_W'(1)) ? S_DONE : S_COLLECT;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Datapath and outputs, registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_remaining  <= '0;
      r_index      <= '0;
      r_lane       <= '0;
      r_word       <= '0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      if (w_start_acc) begin
        r_index     <= '0;
        r_lane      <= '0;
        r_remaining <= w_count_clamped;
      end
      if (w_hs) begin
        r_lane <= r_lane + 2'd1;
        case (r_lane)
          2'd0:    r_word[7:0]   <= bus.byte_data;
          2'd1:    r_word[15:8]  <= bus.byte_data;
          2'd2:    r_word[23:16] <= bus.byte_data;
          default: ;
        endcase
      end
      // The fourth byte goes straight into the write word, bypassing r_word.
      if (w_last_byte) begin
        r_mem_addr  <= 32'({r_index, 2'b00});
        r_mem_wdata <= {bus.byte_data, r_word};
      end
      if (r_state == S_WRITE) begin
        r_index     <= r_index + ADDR_W'(1);
        r_remaining <= r_remaining - CNT_W'(1);
        r_lane      <= '0;
      end
      r_byte_ready <= (w_state_next == S_COLLECT);
      r_mem_we     <= (w_state_next == S_WRITE);
      r_busy       <= (w_state_next != S_IDLE);
      r_done       <= (w_state_next == S_DONE);
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.busy       = r_busy;
  assign bus.cpu_hold   = r_busy;
  assign bus.done       = r_done;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Sum lands the cycle after each write strobe, so it is final while done is high.
  always_ff @(posedge clk) begin
    if (!reset)           r_checksum <= '0;
    else if (w_start_acc) r_checksum <= '0;
    else if (r_mem_we)    r_checksum <= r_checksum + r_mem_wdata;
  end

  assign bus.checksum = r_checksum;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus queues expected writes, monitors pop and compare.
`timescale 1ns/1ps
module tb_instr_mem_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.ADDR_W(8)) bus8 ();
  instr_mem_loader_if #(.ADDR_W(2)) bus2 ();

  instr_mem_loader #(.ADDR_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  instr_mem_loader #(.ADDR_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  q8[$];
  wr_t  q2[$];
  int   we_cyc8[$];
  wr_t  e8, e2;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_wr2    = 0;
  logic prev_we8 = 1'b0;
  logic prev_we2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%08h with nothing expected", name, act);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitors: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    prev_we8 <= (bus8.mem_we === 1'b1);
    if (bus8.mem_we === 1'b1) begin
      check("we_single_cycle8", 32'(prev_we8), 32'd0);
      we_cyc8.push_back(cyc);
      if (q8.size() == 0) flag("unexpected_write8", bus8.mem_addr);
      else begin
        e8 = q8.pop_front();
        check("wr_addr8", bus8.mem_addr, e8.addr);
        check("wr_data8", bus8.mem_wdata, e8.data);
      end
    end
  end

  always @(negedge clk) begin
    prev_we2 <= (bus2.mem_we === 1'b1);
    if (bus2.mem_we === 1'b1) begin
      check("we_single_cycle2", 32'(prev_we2), 32'd0);
      n_wr2 <= n_wr2 + 1;
      if (q2.size() == 0) flag("unexpected_write2", bus2.mem_addr);
      else begin
        e2 = q2.pop_front();
        check("wr_addr2", bus2.mem_addr, e2.addr);
        check("wr_data2", bus2.mem_wdata, e2.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte and return just after the edge that accepted it; valid stays high.
  task automatic send8(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus8.byte_valid = 1'b1;
    bus8.byte_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus8.byte_ready === 1'b1) ok = 1'b1;
      tick();
    end
    if (!ok) flag("send8_timeout", 32'(b));
  endtask

  task automatic send2(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus2.byte_valid = 1'b1;
    bus2.byte_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus2.byte_ready === 1'b1) ok = 1'b1;
      tick();
    end
    if (!ok) flag("send2_timeout", 32'(b));
  endtask

  task automatic wait_done8(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_done2(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(negedge clk);
      if (bus2.done === 1'b1) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  logic [7:0] img [8];
  int         gaps [8];

  initial begin
    img  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    gaps = '{0, 2, 1, 0, 3, 0, 1, 2};

    // Reset with aggressive inputs held active.
    reset = 1'b0;
    bus8.start = 1'b1; bus8.load_words = 9'd2; bus8.byte_valid = 1'b1; bus8.byte_data = 8'hAA;
    bus2.start = 1'b1; bus2.load_words = 3'd2; bus2.byte_valid = 1'b1; bus2.byte_data = 8'hAA;
    tick();
    tick();
    check("rst_byte_ready", 32'(bus8.byte_ready), 32'd0);
    check("rst_mem_we",     32'(bus8.mem_we),     32'd0);
    check("rst_busy",       32'(bus8.busy),       32'd0);
    check("rst_cpu_hold",   32'(bus8.cpu_hold),   32'd0);
    check("rst_done",       32'(bus8.done),       32'd0);
    check("rst_mem_addr",   bus8.mem_addr,        32'd0);
    check("rst_mem_wdata",  bus8.mem_wdata,       32'd0);
    check("rst_busy2",      32'(bus2.busy),       32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("rst_checksum",   bus8.checksum,        32'd0);
`endif
    bus8.start = 1'b0; bus8.byte_valid = 1'b0;
    bus2.start = 1'b0; bus2.byte_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Back-to-back two-word load.
    we_cyc8.delete();
    q8.push_back({32'h0, 32'h12345678});
    q8.push_back({32'h4, 32'hDEADBEEF});
    bus8.start = 1'b1; bus8.load_words = 9'd2;
    tick();
    bus8.start = 1'b0;
    check("start_busy", 32'(bus8.busy), 32'd1);
    check("start_ready", 32'(bus8.byte_ready), 32'd1);
    for (int i = 0; i < 8; i++) send8(img[i]);
    bus8.byte_valid = 1'b0;
    check("last_we", 32'(bus8.mem_we), 32'd1);
    check("last_we_ready", 32'(bus8.byte_ready), 32'd0);
    check("last_we_done", 32'(bus8.done), 32'd0);
    tick();
    check("done_pulse", 32'(bus8.done), 32'd1);
    check("done_busy", 32'(bus8.busy), 32'd1);
    check("done_hold", 32'(bus8.cpu_hold), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    check("checksum_b2b", bus8.checksum, 32'hF0E21567);
`endif
    tick();
    check("post_busy", 32'(bus8.busy), 32'd0);
    check("post_hold", 32'(bus8.cpu_hold), 32'd0);
    check("post_done", 32'(bus8.done), 32'd0);
    check("b2b_write_count", 32'(we_cyc8.size()), 32'd2);
    if (we_cyc8.size() == 2) check("b2b_word_period", 32'(we_cyc8[1] - we_cyc8[0]), 32'd5);

    // Same image with source bubbles.
    q8.push_back({32'h0, 32'h12345678});
    q8.push_back({32'h4, 32'hDEADBEEF});
    bus8.start = 1'b1; bus8.load_words = 9'd2;
    tick();
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus8.byte_valid = 1'b0;
      for (int g = 0; g < gaps[i]; g++) tick();
      send8(img[i]);
    end
    bus8.byte_valid = 1'b0;
    wait_done8("gap_done");
`ifdef LOADER_CHECKSUM_EN
    check("checksum_gap", bus8.checksum, 32'hF0E21567);
`endif
    check("gap_drained", 32'(q8.size()), 32'd0);
    tick();
    tick();

    // Zero-length request.
    bus8.start = 1'b1; bus8.load_words = 9'd0;
    tick();
    bus8.start = 1'b0;
    check("zero_done", 32'(bus8.done), 32'd1);
    check("zero_busy", 32'(bus8.busy), 32'd1);
    check("zero_ready", 32'(bus8.byte_ready), 32'd0);
    tick();
    check("zero_busy_end", 32'(bus8.busy), 32'd0);
    check("zero_done_end", 32'(bus8.done), 32'd0);

    // Reset in the middle of a word, then a fresh one-word load.
    bus8.start = 1'b1; bus8.load_words = 9'd1;
    tick();
    bus8.start = 1'b0;
    send8(8'h78);
    send8(8'h56);
    bus8.byte_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_busy", 32'(bus8.busy), 32'd0);
    check("midrst_ready", 32'(bus8.byte_ready), 32'd0);
    q8.push_back({32'h0, 32'h04030201});
    bus8.start = 1'b1; bus8.load_words = 9'd1;
    tick();
    bus8.start = 1'b0;
    send8(8'h01); send8(8'h02); send8(8'h03); send8(8'h04);
    bus8.byte_valid = 1'b0;
    wait_done8("midrst_done");
`ifdef LOADER_CHECKSUM_EN
    check("checksum_one", bus8.checksum, 32'h04030201);
`endif
    check("midrst_drained", 32'(q8.size()), 32'd0);

    // Clamp on a 4-word memory with a stray start mid-session.
    q2.push_back({32'h0, 32'h13121110});
    q2.push_back({32'h4, 32'h17161514});
    q2.push_back({32'h8, 32'h1B1A1918});
    q2.push_back({32'hC, 32'h1F1E1D1C});
    bus2.start = 1'b1; bus2.load_words = 3'd7;
    tick();
    bus2.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin bus2.start = 1'b1; bus2.load_words = 3'd1; end
      send2(8'(8'h10 + i));
      bus2.start = 1'b0;
    end
    // Keep offering data to expose any extra write beyond capacity.
    bus2.byte_data = 8'hFF;
    wait_done2("clamp_done");
    for (int i = 0; i < 12; i++) tick();
    bus2.byte_valid = 1'b0;
    check("clamp_write_count", 32'(n_wr2), 32'd4);
    check("clamp_drained", 32'(q2.size()), 32'd0);
    check("clamp_idle", 32'(bus2.busy), 32'd0);
    check("clamp_ready", 32'(bus2.byte_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
